// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side blocks: occupancy state encodings
// of the two-entry output buffer and the legal FIFO read-latency settings.
package fifo_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // rdata valid in the same cycle as rinc
  localparam int unsigned RD_LAT_COMB = 0;
  // rdata valid one cycle after rinc
  localparam int unsigned RD_LAT_REG  = 1;

endpackage

// File: rtl/fifo_skid_buf2.sv
// Two-entry FIFO-ordered output buffer with its occupancy FSM.
// out_data always presents the oldest held word and stays stable until popped.
module fifo_skid_buf2
  import fifo_pkg::*;
#(
  parameter int unsigned DATESIZE = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic                pop,
  input  logic [DATESIZE-1:0] push_data,
  output logic [DATESIZE-1:0] out_data,
  output logic                out_valid,
  output occ_e                occ
);

  occ_e                state_q;
  occ_e                state_d;
  logic [DATESIZE-1:0] head_q;
  logic [DATESIZE-1:0] tail_q;

  // Occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OCC_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Occupancy next state: push raises, pop lowers, both together hold
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OCC_EMPTY: if (push) state_d = OCC_ONE;
      OCC_ONE: begin
        if (push && !pop)      state_d = OCC_TWO;
        else if (pop && !push) state_d = OCC_EMPTY;
      end
      OCC_TWO:   if (pop && !push) state_d = OCC_ONE;
      default:   state_d = OCC_EMPTY;
    endcase
  end

  // Data slots: head is the oldest word, tail the younger one when two are held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      unique case (state_q)
        OCC_EMPTY: if (push) head_q <= push_data;
        OCC_ONE: begin
          if (push && pop) head_q <= push_data;
          else if (push)   tail_q <= push_data;
        end
        OCC_TWO: begin
          if (pop) begin
            head_q <= tail_q;
            if (push) tail_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data  = head_q;
  assign out_valid = (state_q != OCC_EMPTY);
  assign occ       = state_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage for async_fifo (rclk domain). Issues FIFO reads only
// when the word is guaranteed a slot in the two-entry output buffer, and
// re-presents the words as a valid/ready stream at up to one beat per cycle.
// Optional feature: define FIFO_RD_LAST_EN to generate out_last every
// BURST_LEN beats; otherwise out_last is tied low.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DATESIZE  = 8,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                rclk,
  input  logic                r_rstn,
  input  logic [DATESIZE-1:0] fifo_rdata,
  input  logic                fifo_rempty,
  output logic                fifo_rinc,
  output logic [DATESIZE-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic [CNT_W-1:0]    beat_cnt
);

  logic       pop;
  logic       push;
  logic       inflight;
  logic [2:0] level;
  occ_e       occ;

  assign pop = out_valid & out_ready;

  // Words held plus words already requested; a pop this cycle frees one slot.
  // Written as level < 2 + pop to avoid an unsigned subtraction.
  assign level     = {1'b0, occ} + {2'b00, inflight};
  assign fifo_rinc = !fifo_rempty && (level < (3'd2 + {2'b00, pop}));

  generate
    if (RD_LAT == RD_LAT_COMB) begin : g_lat_comb
      assign inflight = 1'b0;
      assign push     = fifo_rinc;
    end else begin : g_lat_reg
      logic inflight_q;

      // Remember an issued read so its word is captured when rdata arrives
      always_ff @(posedge rclk or negedge r_rstn) begin
        if (!r_rstn) begin
          inflight_q <= 1'b0;
        end else begin
          inflight_q <= fifo_rinc;
        end
      end

      assign inflight = inflight_q;
      assign push     = inflight_q;
    end
  endgenerate

  fifo_skid_buf2 #(
    .DATESIZE (DATESIZE)
  ) u_buf (
    .clk       (rclk),
    .rst_n     (r_rstn),
    .push      (push),
    .pop       (pop),
    .push_data (fifo_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .occ       (occ)
  );

  // Accepted-beat counter, wraps naturally
  always_ff @(posedge rclk or negedge r_rstn) begin
    if (!r_rstn) begin
      beat_cnt <= '0;
    end else if (pop) begin
      beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

`ifdef FIFO_RD_LAST_EN
  localparam int unsigned IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  logic [IDX_W-1:0] burst_idx;
  logic             idx_at_end;

  assign idx_at_end = (burst_idx == IDX_W'(BURST_LEN - 1));

  // Beat position within the current burst, restarting after the last beat
  always_ff @(posedge rclk or negedge r_rstn) begin
    if (!r_rstn) begin
      burst_idx <= '0;
    end else if (pop) begin
      burst_idx <= idx_at_end ? '0 : burst_idx + IDX_W'(1);
    end
  end

  assign out_last = out_valid & idx_at_end;
`else
  logic unused_burst_len;

  assign unused_burst_len = (BURST_LEN == 0);
  assign out_last         = 1'b0;
`endif

endmodule
